// File: rtl/sram_bus.sv
// sram_bus: single-port synchronous SRAM behind a req/gnt/rvalid bus.
//
// Byte-addressed window starting at BASE, DEPTH words of DATA_W bits,
// per-byte write enables, fixed response latency of READ_LAT (1 or 2)
// cycles. Every accepted request produces exactly one response, in order.
// Accesses below BASE, beyond the last word or not word-aligned respond
// with err_o=1 and leave memory untouched.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   synchronous active-high reset
//   req_i     in   request valid
//   gnt_o     out  request accepted this cycle (req_i & ~rst_i)
//   we_i      in   1 = write, 0 = read
//   be_i      in   byte enables (writes only)
//   addr_i    in   byte address
//   wdata_i   in   write data
//   rvalid_o  out  response valid, one pulse per accepted request
//   rdata_o   out  read data, zero outside read responses
//   err_o     out  response error, zero outside responses
module sram_bus #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] BASE     = '0,
    parameter int                READ_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int LG_B  = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("sram_bus: READ_LAT must be 1 or 2");
    end
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_dw
        $error("sram_bus: DATA_W must be a multiple of 8, at least 8");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Address decode
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_legal;
    logic              w_acc;
    logic              w_wr;

    always_comb begin
        w_off   = addr_i - BASE;
        w_word  = w_off >> LG_B;
        w_idx   = w_word[IDX_W-1:0];
        // Mask form keeps the alignment test valid when BYTES == 1
        w_legal = (addr_i >= BASE)
                  && (w_word < ADDR_W'(DEPTH))
                  && ((w_off & ADDR_W'(BYTES - 1)) == '0);
        w_acc   = req_i & ~rst_i;
        w_wr    = w_acc & we_i & w_legal;
    end

    assign gnt_o = w_acc;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // First response stage: registered at the accept edge.
    // Read data is forced to zero for writes, errors and idle cycles so
    // rdata_o never carries stale contents.
    logic              r_v1;
    logic              r_e1;
    logic [DATA_W-1:0] r_d1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1 <= 1'b0;
            r_e1 <= 1'b0;
            r_d1 <= '0;
        end else begin
            r_v1 <= req_i;
            r_e1 <= req_i & ~w_legal;
            r_d1 <= (req_i & ~we_i & w_legal) ? r_mem[w_idx] : '0;
        end
    end

    logic              w_vout;
    logic              w_eout;
    logic [DATA_W-1:0] w_dout;

    if (READ_LAT == 2) begin : g_lat2
        logic              r_v2;
        logic              r_e2;
        logic [DATA_W-1:0] r_d2;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_v2 <= 1'b0;
                r_e2 <= 1'b0;
                r_d2 <= '0;
            end else begin
                r_v2 <= r_v1;
                r_e2 <= r_e1;
                r_d2 <= r_d1;
            end
        end

        assign w_vout = r_v2;
        assign w_eout = r_e2;
        assign w_dout = r_d2;
    end else begin : g_lat1
        assign w_vout = r_v1;
        assign w_eout = r_e1;
        assign w_dout = r_d1;
    end

    // Outputs are held at their reset values while rst_i is high, so a
    // response that would fall due in the reset cycle is never seen.
    always_comb begin
        rvalid_o = w_vout & ~rst_i;
        err_o    = w_eout & ~rst_i;
        rdata_o  = rst_i ? '0 : w_dout;
    end

endmodule

// File: doc/sram_bus.md
Name: sram_bus

Overview:
- Parametrised single-port synchronous SRAM with a req/gnt/rvalid bus handshake, byte-lane write enables and configurable read latency.
- Byte-addressed with a programmable base. Out-of-range and misaligned accesses are flagged instead of aliasing.
- Sits behind the core's instruction/data LSU ports as the general-purpose on-chip memory and replaces fixed-size word-addressed RAMs.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, minimum 8.
- DEPTH, 1024, number of DATA_W words; power of two.
- ADDR_W, 32, byte address width.
- BASE, 0, byte address of word 0; aligned to DATA_W/8.
- READ_LAT, 1, response latency in cycles; legal values 1 or 2.

Ports:
- clk_i, in, 1, clock; all logic on the rising edge.
- rst_i, in, 1, synchronous active-high reset.
- req_i, in, 1, request valid.
- gnt_o, out, 1, request accepted this cycle.
- we_i, in, 1, 1 = write, 0 = read.
- be_i, in, DATA_W/8, byte enables for writes; ignored on reads.
- addr_i, in, ADDR_W, byte address.
- wdata_i, in, DATA_W, write data.
- rvalid_o, out, 1, response valid; one pulse per accepted request.
- rdata_o, out, DATA_W, read data; valid when rvalid_o is high.
- err_o, out, 1, response error; valid when rvalid_o is high.

Behaviour:
- Reset values: rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0.
  - All in-flight responses are dropped.
  - Memory array contents are not reset.
  - A request presented in a cycle where rst_i=1 is not accepted and has no effect.
- Grant: gnt_o = req_i & ~rst_i (combinational). The block is fully pipelined and accepts one request every cycle with no back-pressure.
- Address decode:
  - off = addr_i - BASE.
  - idx = off >> log2(DATA_W/8).
  - The access is illegal if addr_i < BASE, idx >= DEPTH, or off[log2(DATA_W/8)-1:0] != 0.
- Legal write: on the accept edge, byte lane k of mem[idx] takes wdata_i lane k where be_i[k]=1; other lanes are unchanged. be_i=0 is legal: no change, still responds.
- Illegal access: no memory update, response has err_o=1 and rdata_o=0.
- Legal read: response carries mem[idx] as of the accept edge.
- Write response: err_o per decode, rdata_o=0.
- Latency: each accepted request yields exactly one response with rvalid_o=1 exactly READ_LAT cycles after the accept edge.
  - READ_LAT=1: memory output presented directly.
  - READ_LAT=2: one output register stage.
  - Responses are returned in order; back-to-back requests give back-to-back rvalid pulses.
- Ordering: a write accepted in cycle N followed by a read of the same word in cycle N+1 returns the written data (no stale data).
- Outside response cycles, rvalid_o=0, err_o=0, rdata_o=0. rdata_o must not hold stale data.
- Reset mid-operation: responses pending at the reset edge are never issued. The first response after reset belongs to the first request accepted after rst_i deasserts.
- Illegal READ_LAT values fail elaboration with a generate-time error.

Test Plan:
- Reset, then write addr=0x0 data=0xDEADBEEF be=0xF, then read addr=0x0 -> write response err=0 rdata=0; read response rvalid exactly READ_LAT cycles after grant with rdata=0xDEADBEEF, err=0 (run for READ_LAT=1 and 2).
- Write 0x11223344 be=0xF to 0x8, then write 0xAABBCCDD be=0x5 to 0x8, then read 0x8 -> 0x11BB33DD.
- Back-to-back: write 0x4=0x5A5A5A5A in cycle N, read 0x4 in cycle N+1, read 0x0 in N+2 -> three consecutive rvalid pulses; reads return 0x5A5A5A5A then mem[0].
- DEPTH=16, BASE=0x1000:
  - Read 0x0FFC, read 0x1040 and read 0x1002 -> each gives rvalid with err=1, rdata=0.
  - Write 0x1040 then legal read 0x103C -> 0x103C contents unchanged.
- READ_LAT=2: issue reads at 0x0 and 0x4, assert rst_i the cycle after the second grant -> no rvalid for either read; a post-reset read of 0x0 returns the pre-reset contents after 2 cycles.
- Write with be=0x0 to 0xC holding 0x12345678 -> response err=0; subsequent read returns 0x12345678.
